// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with skid buffer: decodes RV immediates, format and PC target.
// Optional build macro IMM_GEN_CSR_EN: CSR*I instructions return zero-extended zimm with format 6.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int FMT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [FMT_W-1:0] out_fmt,
  output logic             out_illegal,
  output logic [XLEN-1:0]  out_target,
  output logic [31:0]      out_instr
);

  localparam int DEC_W = XLEN + FMT_W + 1;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;

  localparam logic [FMT_W-1:0] FMT_R   = FMT_W'(0);
  localparam logic [FMT_W-1:0] FMT_I   = FMT_W'(1);
  localparam logic [FMT_W-1:0] FMT_S   = FMT_W'(2);
  localparam logic [FMT_W-1:0] FMT_B   = FMT_W'(3);
  localparam logic [FMT_W-1:0] FMT_U   = FMT_W'(4);
  localparam logic [FMT_W-1:0] FMT_J   = FMT_W'(5);
  localparam logic [FMT_W-1:0] FMT_CSR = FMT_W'(6);

  // Returns {illegal, fmt, imm}; every immediate is built as signed 32-bit, then widened to XLEN.
  function automatic logic [DEC_W-1:0] decode(input logic [31:0] ins);
    logic signed [31:0] simm;
    logic [FMT_W-1:0]   fmt;
    logic               ill;
    logic               zext;
    logic [XLEN-1:0]    imm;
    simm = '0;
    fmt  = FMT_R;
    ill  = 1'b0;
    zext = 1'b0;
    case (ins[6:0])
      OP_IMM, OP_LOAD, OP_JALR: begin
        simm = 32'($signed(ins[31:20]));
        fmt  = FMT_I;
      end
      OP_SYS: begin
        simm = 32'($signed(ins[31:20]));
        fmt  = FMT_I;
`ifdef IMM_GEN_CSR_EN
        if (ins[14]) begin
          zext = 1'b1;
          fmt  = FMT_CSR;
        end
`endif
      end
      OP_STORE: begin
        simm = 32'($signed({ins[31:25], ins[11:7]}));
        fmt  = FMT_S;
      end
      OP_BRANCH: begin
        simm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        fmt  = FMT_B;
      end
      OP_LUI, OP_AUIPC: begin
        simm = $signed({ins[31:12], 12'b0});
        fmt  = FMT_U;
      end
      OP_JAL: begin
        simm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
        fmt  = FMT_J;
      end
      OP_REG: fmt = FMT_R;
      OP_IMM32: begin
        if (XLEN == 64) begin
          simm = 32'($signed(ins[31:20]));
          fmt  = FMT_I;
        end else begin
          ill = 1'b1;
        end
      end
      default: ill = 1'b1;
    endcase
    imm = zext ? XLEN'(ins[19:15]) : XLEN'(simm);
    return {ill, fmt, imm};
  endfunction

  logic [XLEN-1:0]  imm_p0, tgt_p0;
  logic [FMT_W-1:0] fmt_p0;
  logic             ill_p0;

  always_comb begin
    {ill_p0, fmt_p0, imm_p0} = decode(in_instr);
    tgt_p0 = in_pc + imm_p0;
  end

  // ---- stage p1: main output register plus skid entry ----
  logic             vld_p1, sk_vld_p1;
  logic [XLEN-1:0]  imm_p1, tgt_p1, sk_imm_p1, sk_tgt_p1;
  logic [FMT_W-1:0] fmt_p1, sk_fmt_p1;
  logic             ill_p1, sk_ill_p1;
  logic [31:0]      ins_p1, sk_ins_p1;
  logic             acc, load_main;

  assign in_ready  = !sk_vld_p1;
  assign acc       = in_valid && in_ready;
  assign load_main = !vld_p1 || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      sk_vld_p1 <= 1'b0;
    end else if (flush) begin
      vld_p1    <= 1'b0;
      sk_vld_p1 <= 1'b0;
    end else if (load_main) begin
      vld_p1    <= sk_vld_p1 || acc;
      sk_vld_p1 <= 1'b0;
    end else if (acc) begin
      sk_vld_p1 <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imm_p1 <= '0;
      tgt_p1 <= '0;
      fmt_p1 <= '0;
      ill_p1 <= 1'b0;
      ins_p1 <= '0;
    end else if (load_main && sk_vld_p1) begin
      imm_p1 <= sk_imm_p1;
      tgt_p1 <= sk_tgt_p1;
      fmt_p1 <= sk_fmt_p1;
      ill_p1 <= sk_ill_p1;
      ins_p1 <= sk_ins_p1;
    end else if (load_main && acc) begin
      imm_p1 <= imm_p0;
      tgt_p1 <= tgt_p0;
      fmt_p1 <= fmt_p0;
      ill_p1 <= ill_p0;
      ins_p1 <= in_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (!load_main && acc) begin
      sk_imm_p1 <= imm_p0;
      sk_tgt_p1 <= tgt_p0;
      sk_fmt_p1 <= fmt_p0;
      sk_ill_p1 <= ill_p0;
      sk_ins_p1 <= in_instr;
    end
  end

  assign out_valid   = vld_p1;
  assign out_imm     = imm_p1;
  assign out_target  = tgt_p1;
  assign out_fmt     = fmt_p1;
  assign out_illegal = ill_p1;
  assign out_instr   = ins_p1;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: an XLEN=32 instance for handshake/decode, an XLEN=64 instance for widening.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_instr, in_pc, out_imm, out_target, out_instr;
  logic [2:0]  out_fmt;

  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_illegal;
  logic [31:0] b_in_instr, b_out_instr;
  logic [63:0] b_in_pc, b_out_imm, b_out_target;
  logic [2:0]  b_out_fmt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .FMT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt),
    .out_illegal(out_illegal), .out_target(out_target), .out_instr(out_instr)
  );

  imm_gen_pipe #(.XLEN(64), .FMT_W(3)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr), .in_pc(b_in_pc),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_imm(b_out_imm), .out_fmt(b_out_fmt),
    .out_illegal(b_out_illegal), .out_target(b_out_target), .out_instr(b_out_instr)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
  endtask

  task automatic drive64(input logic [31:0] ins, input logic [63:0] pc);
    b_in_valid = 1'b1;
    b_in_instr = ins;
    b_in_pc    = pc;
  endtask

  logic [31:0] s_ins [4] = '{32'h0220ABA3, 32'h02208E63, 32'hF9DFF16F, 32'h51000137};
  logic [31:0] s_imm [4] = '{32'h37, 32'h3C, 32'hFFFFFF9C, 32'h51000000};
  logic [2:0]  s_fmt [4] = '{3'd2, 3'd3, 3'd5, 3'd4};
  logic [31:0] s_tgt [4] = '{32'h237, 32'h23C, 32'h19C, 32'h51000200};

  initial begin
    flush = 0; in_valid = 0; in_instr = '0; in_pc = '0; out_ready = 1;
    b_flush = 0; b_in_valid = 0; b_in_instr = '0; b_in_pc = '0; b_out_ready = 1;

    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_imm", out_imm, 0);
    chk("rst_out_target", out_target, 0);
    chk("rst_out_fmt", out_fmt, 0);
    chk("rst_out_illegal", out_illegal, 0);
    chk("rst_out_instr", out_instr, 0);
    rst_n = 1'b1;
    tick();

    // single addi entry
    drive(32'h00508113, 32'h100);
    tick();
    in_valid = 0;
    chk("addi_valid", out_valid, 1);
    chk("addi_imm", out_imm, 32'h5);
    chk("addi_fmt", out_fmt, 1);
    chk("addi_target", out_target, 32'h105);
    chk("addi_illegal", out_illegal, 0);
    chk("addi_instr", out_instr, 32'h00508113);
    tick();
    chk("addi_drained", out_valid, 0);

    // back-to-back stream at full rate
    for (int i = 0; i < 4; i++) begin
      drive(s_ins[i], 32'h200);
      tick();
      chk($sformatf("stream%0d_valid", i), out_valid, 1);
      chk($sformatf("stream%0d_instr", i), out_instr, s_ins[i]);
      chk($sformatf("stream%0d_imm", i), out_imm, s_imm[i]);
      chk($sformatf("stream%0d_fmt", i), out_fmt, s_fmt[i]);
      chk($sformatf("stream%0d_target", i), out_target, s_tgt[i]);
      chk($sformatf("stream%0d_in_ready", i), in_ready, 1);
    end
    in_valid = 0;
    tick();
    chk("stream_drained", out_valid, 0);

    // backpressure: two stored, third held upstream
    out_ready = 0;
    drive(32'h00100093, 32'h0);
    tick();
    chk("bp_ready_after_a", in_ready, 1);
    drive(32'h00200093, 32'h0);
    tick();
    chk("bp_ready_after_b", in_ready, 0);
    chk("bp_hold_a", out_instr, 32'h00100093);
    drive(32'h00300093, 32'h0);
    tick();
    chk("bp_stall_ready", in_ready, 0);
    chk("bp_stall_valid", out_valid, 1);
    chk("bp_stall_instr", out_instr, 32'h00100093);
    chk("bp_stall_imm", out_imm, 32'h1);
    out_ready = 1;
    tick();
    chk("bp_rel_b_instr", out_instr, 32'h00200093);
    chk("bp_rel_b_imm", out_imm, 32'h2);
    chk("bp_rel_ready", in_ready, 1);
    tick();
    in_valid = 0;
    chk("bp_rel_c_valid", out_valid, 1);
    chk("bp_rel_c_instr", out_instr, 32'h00300093);
    tick();
    chk("bp_drained", out_valid, 0);

    // flush with main and skid full, in_valid high
    out_ready = 0;
    drive(32'h00100093, 32'h0);
    tick();
    drive(32'h00200093, 32'h0);
    tick();
    chk("fl_full_ready", in_ready, 0);
    drive(32'h00400093, 32'h0);
    flush = 1;
    tick();
    flush = 0;
    in_valid = 0;
    chk("fl_valid", out_valid, 0);
    chk("fl_ready", in_ready, 1);
    out_ready = 1;
    tick();
    chk("fl_no_ghost", out_valid, 0);

    // flush discards an entry accepted in the same cycle
    out_ready = 0;
    drive(32'h00100093, 32'h0);
    tick();
    drive(32'h00400093, 32'h0);
    flush = 1;
    tick();
    flush = 0;
    in_valid = 0;
    out_ready = 1;
    chk("fl2_valid", out_valid, 0);
    tick();
    chk("fl2_no_ghost", out_valid, 0);

    // illegal opcodes on XLEN=32
    drive(32'h0000007F, 32'h40);
    tick();
    chk("ill_flag", out_illegal, 1);
    chk("ill_imm", out_imm, 0);
    chk("ill_fmt", out_fmt, 0);
    drive(32'h0050809B, 32'h40);
    tick();
    chk("ill_imm32_flag", out_illegal, 1);
    chk("ill_imm32_imm", out_imm, 0);

    // CSR register form and immediate form
    drive(32'h34001073, 32'h0);
    tick();
    chk("csrrw_fmt", out_fmt, 1);
    chk("csrrw_imm", out_imm, 32'h340);
    drive(32'h3400D073, 32'h0);
    tick();
    in_valid = 0;
`ifdef IMM_GEN_CSR_EN
    chk("csrrwi_fmt", out_fmt, 6);
    chk("csrrwi_imm", out_imm, 32'h1);
`else
    chk("csrrwi_fmt", out_fmt, 1);
    chk("csrrwi_imm", out_imm, 32'h340);
`endif
    tick();

    // XLEN=64 instance
    drive64(32'h0050809B, 64'h1000);
    tick();
    chk("x64_addiw_fmt", b_out_fmt, 1);
    chk("x64_addiw_imm", b_out_imm, 64'h5);
    chk("x64_addiw_ill", b_out_illegal, 0);
    chk("x64_addiw_target", b_out_target, 64'h1005);
    drive64(32'hF9DFF16F, 64'h200);
    tick();
    chk("x64_jal_imm", b_out_imm, 64'hFFFFFFFFFFFFFF9C);
    chk("x64_jal_target", b_out_target, 64'h19C);
    drive64(32'h80000037, 64'h0);
    tick();
    b_in_valid = 0;
    chk("x64_lui_imm", b_out_imm, 64'hFFFFFFFF80000000);
    chk("x64_lui_fmt", b_out_fmt, 4);
    tick();

    // asynchronous reset between edges
    out_ready = 0;
    drive(32'h00100093, 32'h0);
    tick();
    in_valid = 0;
    chk("arst_pre_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_imm", out_imm, 0);
    tick();
    rst_n = 1'b1;
    out_ready = 1;
    tick();
    chk("arst_stays_empty", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
